// File: rtl/arc4_key_search.sv
`default_nettype none
// ============================================================================
// Module      : arc4_key_search
// Description : Steps the arc4 decryption core through a range of candidate
//               keys. After each decryption it reads the length-prefixed
//               plaintext back and stops on the first key whose plaintext is
//               entirely printable ASCII, or when the range runs out.
// Revision    : 1.0 - initial release
// ============================================================================
module arc4_key_search #(
    parameter int KEY_W      = 24,
    parameter int KEY_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_first,
    input  logic [KEY_W-1:0] key_last,
    output logic [KEY_W-1:0] arc4_key,
    output logic             arc4_en,
    input  logic             arc4_rdy,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] key_found
);

    // Stride widened by one bit so the increment exposes its carry out
    localparam logic [KEY_W:0] c_stride = (KEY_W+1)'(KEY_STRIDE);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LAUNCH    = 4'd1,
        S_WAIT_BUSY = 4'd2,
        S_WAIT_DONE = 4'd3,
        S_RD_LEN    = 4'd4,
        S_LATCH_LEN = 4'd5,
        S_CHECK     = 4'd6,
        S_TEST      = 4'd7,
        S_NEXT      = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_cur;
    logic [KEY_W-1:0] r_last;
    logic [7:0]       r_len;
    logic [7:0]       r_idx;

    logic [KEY_W:0]   w_sum;
    logic [KEY_W-1:0] w_next_key;
    logic             w_exhausted;
    logic             w_byte_ok;

    // Next candidate and the end-of-range test; a carry out counts as exhausted
    always_comb begin
        w_sum       = {1'b0, r_cur} + c_stride;
        w_next_key  = w_sum[KEY_W-1:0];
        w_exhausted = w_sum[KEY_W] || (w_next_key > r_last);
        w_byte_ok   = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);
    end

    // Search sequencer: launch arc4, wait for it, then scan the plaintext
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_last    <= '0;
            r_len     <= 8'd0;
            r_idx     <= 8'd0;
            arc4_key  <= '0;
            arc4_en   <= 1'b0;
            pt_addr   <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            key_found <= '0;
        end else begin
            // The start pulse is only ever a single cycle wide
            arc4_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cur   <= key_first;
                        r_last  <= key_last;
                        found   <= 1'b0;
                        pt_addr <= 8'd0;
                        if (key_first > key_last) begin
                            // Empty range: finish without touching arc4
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            arc4_key <= key_first;
                            r_state  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    arc4_key <= r_cur;
                    if (arc4_rdy) begin
                        arc4_en <= 1'b1;
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (!arc4_rdy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (arc4_rdy) begin
                        pt_addr <= 8'd0;
                        r_state <= S_RD_LEN;
                    end
                end
                S_RD_LEN: begin
                    // Address 0 is presented this cycle; data arrives next
                    r_state <= S_LATCH_LEN;
                end
                S_LATCH_LEN: begin
                    r_len   <= pt_rddata;
                    r_idx   <= 8'd1;
                    pt_addr <= 8'd1;
                    if (pt_rddata == 8'd0) begin
                        // Empty message is trivially printable
                        found     <= 1'b1;
                        key_found <= r_cur;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_state <= S_TEST;
                end
                S_TEST: begin
                    if (!w_byte_ok) begin
                        r_state <= S_NEXT;
                    end else if (r_idx == r_len) begin
                        // Compare before incrementing so index 255 never wraps
                        found     <= 1'b1;
                        key_found <= r_cur;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        pt_addr <= r_idx + 8'd1;
                        r_state <= S_CHECK;
                    end
                end
                S_NEXT: begin
                    if (w_exhausted) begin
                        found   <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cur    <= w_next_key;
                        arc4_key <= w_next_key;
                        r_state  <= S_LAUNCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arc4_key_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_arc4_key_search
// Description : Directed bench for arc4_key_search with a behavioural arc4
//               model and plaintext memory shared by a stride-1 and a
//               stride-4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arc4_key_search;

    typedef struct {
        int          mode;
        logic        sel;
        logic [23:0] first;
        logic [23:0] last;
        logic        exp_found;
        logic [23:0] exp_key;
        int          exp_en;
        int          exp_max_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [23:0] first = '0;
    logic [23:0] last = '0;
    logic        sel = 1'b0;
    int          mode = 0;
    logic        mon_clr = 1'b0;

    logic [23:0] key0, key1, kf0, kf1;
    logic        en0, en1, busy0, busy1, done0, done1, found0, found1;
    logic [7:0]  addr0, addr1;
    logic        rdy = 1'b1;
    logic [7:0]  rddata = 8'd0;

    logic [23:0] m_key, s_key_found;
    logic        m_en, s_busy, s_done, s_found;
    logic [7:0]  m_addr;

    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    arc4_key_search #(.KEY_W(24), .KEY_STRIDE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .key_first(first), .key_last(last),
        .arc4_key(key0), .arc4_en(en0), .arc4_rdy(rdy), .pt_addr(addr0),
        .pt_rddata(rddata), .busy(busy0), .done(done0), .found(found0),
        .key_found(kf0)
    );

    arc4_key_search #(.KEY_W(24), .KEY_STRIDE(4)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .key_first(first), .key_last(last),
        .arc4_key(key1), .arc4_en(en1), .arc4_rdy(rdy), .pt_addr(addr1),
        .pt_rddata(rddata), .busy(busy1), .done(done1), .found(found1),
        .key_found(kf1)
    );

    // Route the active instance to the shared arc4 model and memory
    always_comb begin
        m_en        = sel ? en1 : en0;
        m_key       = sel ? key1 : key0;
        m_addr      = sel ? addr1 : addr0;
        s_busy      = sel ? busy1 : busy0;
        s_done      = sel ? done1 : done0;
        s_found     = sel ? found1 : found0;
        s_key_found = sel ? kf1 : kf0;
    end

    // Behavioural arc4: 20 busy cycles, then plaintext depends on mode and key
    logic [7:0]  mem [0:255];
    int          cnt = 0;
    logic [23:0] kl = '0;
    int          en_cnt = 0;
    logic [23:0] klog [0:127];
    int          viol = 0;
    logic        prev_en = 1'b0;
    int          max_addr = 0;

    always @(posedge clk) begin
        rddata  <= mem[m_addr];
        prev_en <= m_en;
        if ((m_en && !rdy) || (m_en && prev_en) || (rst && (en0 || en1)))
            viol <= viol + 1;
        if (mon_clr)
            max_addr <= 0;
        else if (s_busy && int'(m_addr) > max_addr)
            max_addr <= int'(m_addr);
        if (m_en) begin
            if (en_cnt < 128) klog[en_cnt] <= m_key;
            en_cnt <= en_cnt + 1;
            rdy    <= 1'b0;
            cnt    <= 20;
            kl     <= m_key;
        end else if (!rdy) begin
            if (cnt == 1) begin
                rdy <= 1'b1;
                case (mode)
                    0: begin
                        mem[0] <= 8'd2;
                        mem[1] <= (kl == 24'd3) ? 8'h48 : 8'h01;
                        mem[2] <= (kl == 24'd3) ? 8'h49 : 8'h41;
                    end
                    1: mem[0] <= 8'd0;
                    2: begin
                        mem[0] <= 8'd255;
                        for (int k = 1; k < 256; k++) mem[k] <= 8'h41;
                    end
                    default: begin
                        mem[0] <= 8'd2;
                        mem[1] <= 8'h7F;
                        mem[2] <= 8'h41;
                    end
                endcase
            end
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic run(input vec_t v, input string nm);
        int          base;
        int          cyc;
        int          kmis;
        int          stride;
        logic [23:0] ek;
        stride  = v.sel ? 4 : 1;
        mode    = v.mode;
        sel     = v.sel;
        first   = v.first;
        last    = v.last;
        base    = en_cnt;
        mon_clr = 1'b1;
        if (v.sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0  = 1'b0;
        start1  = 1'b0;
        mon_clr = 1'b0;
        cyc     = 1;
        while (!s_done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, s_done, 1);
        chk({nm, "_busy"}, s_busy, 0);
        chk({nm, "_found"}, s_found, v.exp_found);
        if (v.exp_found) chk({nm, "_key_found"}, s_key_found, v.exp_key);
        chk({nm, "_en_pulses"}, en_cnt - base, v.exp_en);
        kmis = 0;
        for (int k = 0; k < v.exp_en; k++) begin
            ek = v.first + 24'(k * stride);
            if (klog[base + k] !== ek) kmis++;
        end
        chk({nm, "_key_sequence_errors"}, kmis, 0);
        chk({nm, "_max_pt_addr"}, max_addr, v.exp_max_addr);
        if (v.first > v.last) chk({nm, "_empty_latency_ok"}, (cyc <= 2), 1);
    endtask

    vec_t vecs [7];
    vec_t vrst;

    initial begin
        int cyc;
        int base;
        // mode, sel, first, last, found, key, en pulses, max pt_addr
        vecs[0] = '{1, 1'b0, 24'd0, 24'd0, 1'b1, 24'd0, 1, 0};
        vecs[1] = '{2, 1'b0, 24'd0, 24'd0, 1'b1, 24'd0, 1, 255};
        vecs[2] = '{3, 1'b0, 24'd0, 24'd0, 1'b0, 24'd0, 1, 1};
        vecs[3] = '{0, 1'b0, 24'd5, 24'd2, 1'b0, 24'd0, 0, 0};
        vecs[4] = '{0, 1'b1, 24'hFFFFFE, 24'hFFFFFF, 1'b0, 24'd0, 1, 1};
        vecs[5] = '{0, 1'b0, 24'd4, 24'd10, 1'b0, 24'd0, 7, 1};
        vecs[6] = '{0, 1'b0, 24'd0, 24'd10, 1'b1, 24'd3, 4, 2};
        vrst    = '{0, 1'b0, 24'd2, 24'd10, 1'b1, 24'd3, 2, 2};

        repeat (3) @(negedge clk);
        chk("rst_arc4_key", key0, 0);
        chk("rst_arc4_en", en0, 0);
        chk("rst_pt_addr", addr0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_found", found0, 0);
        chk("rst_key_found", kf0, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run(vecs[i], $sformatf("vec%0d", i));

        // Reset while arc4 is running, then restart from a new first key
        mode = 0; sel = 1'b0; first = 24'd1; last = 24'd10;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        cyc = 0;
        while (rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_arc4_running", rdy, 0);
        repeat (3) @(negedge clk);
        base = en_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_arc4_key", key0, 0);
        chk("midrst_arc4_en", en0, 0);
        chk("midrst_pt_addr", addr0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_found", found0, 0);
        chk("midrst_key_found", kf0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_en_pulse", en_cnt - base, 0);
        run(vrst, "restart");

        chk("handshake_violations", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arc4_key_search.md
# arc4_key_search

Controller that sequences the `arc4` decryption core over a range of candidate keys. It owns the `en`/`rdy` handshake and the 24-bit `key` input of `arc4`. After each decryption it reads back the length-prefixed plaintext memory and tests every character for printable ASCII. It sits between the top-level task wrapper (switches, KEYs, HEX displays) and one `arc4` instance plus its `pt_mem` read port. It stops on the first key whose plaintext is fully printable, or when the range is exhausted.

## Interface
- `KEY_W`, 24, width of key and range bounds
- `KEY_STRIDE`, 1, increment between consecutive candidate keys (≥1)
- `clk` in 1: system clock (CLOCK_50)
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: level; sampled in IDLE/DONE, launches a search
- `key_first` in KEY_W: first candidate, captured at launch
- `key_last` in KEY_W: last allowed candidate, inclusive, captured at launch
- `arc4_key` out KEY_W: key driven to `arc4`
- `arc4_en` out 1: one-cycle start pulse to `arc4`
- `arc4_rdy` in 1: `arc4` ready
- `pt_addr` out 8: read address to `pt_mem` (1-cycle synchronous read latency)
- `pt_rddata` in 8: `pt_mem` read data
- `busy` out 1: search in progress
- `done` out 1: search finished, held until next launch
- `found` out 1: valid when `done`; 1 = `key_found` valid
- `key_found` out KEY_W: winning key

Clock and reset are one clock, asynchronous active-high reset, as decided.

## Operation
- Reset values: `arc4_key`=0, `arc4_en`=0, `pt_addr`=0, `busy`=0, `done`=0, `found`=0, `key_found`=0, state=IDLE.
- IDLE/DONE, `start`=1: capture bounds and set `cur`=`key_first`. Set `busy`=1, `done`=0, `found`=0. If `key_first` > `key_last`, go to DONE with `found`=0 and do not pulse `arc4_en`. Otherwise go to LAUNCH.
- LAUNCH: `arc4_key`=`cur`. When `arc4_rdy`=1, assert `arc4_en` for exactly one cycle, then go to WAIT_BUSY. If `arc4_rdy`=0, wait.
- WAIT_BUSY: wait for `arc4_rdy`=0, then go to WAIT_DONE.
- WAIT_DONE: wait for `arc4_rdy`=1, then go to RD_LEN.
- `arc4_key` stays stable from LAUNCH until the next LAUNCH.
- RD_LEN: `pt_addr`=0. Next cycle, latch `len`=`pt_rddata`. Set `i`=1. Go to CHECK.
- CHECK: issue `pt_addr`=`i`. One cycle later, test `pt_rddata`.
- Pass condition for a byte: 0x20 ≤ byte ≤ 0x7E.
- Fail on any byte: go to NEXT immediately; remaining bytes are not read.
- All of bytes 1..`len` pass: set `found`=1, `key_found`=`cur`, go to DONE.
- `len`=0: vacuously passes, so `found`=1.
- `len`=255: address 255 is read; `i` must not wrap to 0.
- NEXT: compute `cur`+`KEY_STRIDE` in KEY_W+1 bits.
  - Carry out, or result > `key_last`: go to DONE with `found`=0.
  - Otherwise update `cur` and go to LAUNCH.
- DONE: `busy`=0, `done`=1. Outputs hold until a new `start`. `start` while `busy` is ignored.
- Reset mid-operation: immediate return to reset values. No `arc4_en` pulse follows. `arc4` is reset separately by its own `rst_n`.

## Timing
- Launch: `start` sampled at edge N; LAUNCH at N+1; `arc4_en` high the first cycle in LAUNCH with `arc4_rdy`=1.
- The controller never asserts `arc4_en` while `arc4_rdy`=0.
- Check cost per key: 2 cycles for length, then 2 cycles per byte read (address then compare), then 1 cycle in NEXT. The `arc4` run time comes on top.
- `done`, `found` and `key_found` update on the same edge.
- `pt_addr` is registered. `pt_mem` is not written by this block; `arc4` owns `pt_wren`, and reads occur only after `arc4` has returned to ready.

## Test plan
- `arc4` model: behavioural, with a fixed 20-cycle busy and writes plaintext "HI" (len 2, 0x48 0x49) only for key 0x000003, else 0x01 at byte 1; `key_first`=0, `key_last`=10 -> `arc4_en` pulsed 4 times with keys 0,1,2,3; `done`=1, `found`=1, `key_found`=0x000003.
- Same model, `key_first`=4, `key_last`=10 -> keys 4..10 tried, `done`=1, `found`=0; `arc4_key` never exceeds 10.
- `key_first`=5, `key_last`=2 -> `done`=1, `found`=0 within 2 cycles, zero `arc4_en` pulses.
- `key_first`=0xFFFFFE, `key_last`=0xFFFFFF, `KEY_STRIDE`=4, no match -> one attempt at 0xFFFFFE; the carry ends the search (no wrap to 0x000002); `found`=0.
- Length boundaries, with key 0 and one run each:
  - `len`=0 -> `found`=1, `key_found`=0.
  - `len`=255, all 0x41 -> `pt_addr` reaches 255, `found`=1.
  - Byte 0x7F at index 1 -> key rejected after one byte read.
- Assert `rst` while in WAIT_DONE -> all outputs at reset values on the next sampled edge. A later `start` restarts from `key_first`. No `arc4_en` pulse while `rst`=1.
